modmul_word_io: RTL and testbench

Word-serial front/back end for the 256-bit modular multiplier core (ports clk, rst, start, X, Y, Q, done).
- Assembles X and Y from a 32-bit valid/ready input stream.
- Pulses the core's start, waits for done, captures Q.
- Streams Q out as 32-bit words with valid/ready and a last flag.
- Sits between the bus/host interface and the multiplier core.

---
 rtl/modmul_word_io.sv | 123 ++++++++++++
 tb/tb_modmul_word_io.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_word_io.sv
// Word-serial front/back end for the 256-bit modular multiplier core:
// assembles X/Y from a word stream, runs the core, streams Q back out.
module modmul_word_io #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              mm_start,
  output logic [OP_W-1:0]   mm_X,
  output logic [OP_W-1:0]   mm_Y,
  input  logic [OP_W-1:0]   mm_Q,
  input  logic              mm_done,
  output logic              busy
);

  localparam int NWORDS = OP_W / WORD_W;
  localparam int CNT_W  = $clog2(NWORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_X = 3'd1,
    S_LOAD_Y = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  in_cnt_r;
  logic [CNT_W-1:0]  out_cnt_r;
  logic [OP_W-1:0]   x_r;
  logic [OP_W-1:0]   y_r;
  logic [OP_W-1:0]   res_r;
  logic              in_acc_s;
  logic              out_acc_s;

  // Every output comes straight from a register or a decode of the state register.
  assign in_ready  = (state_r == S_LOAD_X) || (state_r == S_LOAD_Y);
  assign mm_start  = (state_r == S_START);
  assign out_valid = (state_r == S_DRAIN);
  assign out_last  = (state_r == S_DRAIN) && (out_cnt_r == LAST_IDX);
  assign busy      = (state_r != S_IDLE) && (state_r != S_LOAD_X);
  assign out_data  = res_r[WORD_W-1:0];
  assign mm_X      = x_r;
  assign mm_Y      = y_r;

  assign in_acc_s  = in_valid && in_ready;
  assign out_acc_s = out_valid && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   state_nxt_s = S_LOAD_X;
      S_LOAD_X: begin
        if (in_acc_s && (in_cnt_r == LAST_IDX)) state_nxt_s = S_LOAD_Y;
        else                                    state_nxt_s = S_LOAD_X;
      end
      S_LOAD_Y: begin
        if (in_acc_s && (in_cnt_r == LAST_IDX)) state_nxt_s = S_START;
        else                                    state_nxt_s = S_LOAD_Y;
      end
      S_START:  state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (mm_done) state_nxt_s = S_DRAIN;
        else         state_nxt_s = S_WAIT;
      end
      S_DRAIN: begin
        if (out_acc_s && (out_cnt_r == LAST_IDX)) state_nxt_s = S_LOAD_X;
        else                                      state_nxt_s = S_DRAIN;
      end
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Operand assembly (little-endian word order) and result shift-out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
      x_r       <= '0;
      y_r       <= '0;
      res_r     <= '0;
    end else begin
      if (in_acc_s) begin
        in_cnt_r <= in_cnt_r + 1'b1;
        for (int k = 0; k < NWORDS; k++) begin
          if (in_cnt_r == CNT_W'(k)) begin
            if (state_r == S_LOAD_X) x_r[k*WORD_W +: WORD_W] <= in_data;
            else                     y_r[k*WORD_W +: WORD_W] <= in_data;
          end
        end
      end
      if ((state_r == S_WAIT) && mm_done) begin
        res_r     <= mm_Q;
        out_cnt_r <= '0;
      end else if (out_acc_s) begin
        res_r     <= res_r >> WORD_W;
        out_cnt_r <= out_cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_modmul_word_io.sv
// Self-checking bench for modmul_word_io: operands and results are modelled
// as word arrays and compared against the packed/streamed DUT values.
module tb_modmul_word_io;
  localparam int WORD_W = 32;
  localparam int OP_W   = 256;
  localparam int NWORDS = OP_W / WORD_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              mm_start;
  logic [OP_W-1:0]   mm_X;
  logic [OP_W-1:0]   mm_Y;
  logic [OP_W-1:0]   mm_Q;
  logic              mm_done;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WORD_W-1:0] xw [NWORDS];
  logic [WORD_W-1:0] yw [NWORDS];
  logic [WORD_W-1:0] qw [NWORDS];

  modmul_word_io #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .mm_start(mm_start), .mm_X(mm_X), .mm_Y(mm_Y), .mm_Q(mm_Q), .mm_done(mm_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [OP_W-1:0] got, input logic [OP_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OP_W-1:0] pack(input logic [WORD_W-1:0] w [NWORDS]);
    logic [OP_W-1:0] r;
    r = '0;
    for (int k = 0; k < NWORDS; k++) r = r | (OP_W'(w[k]) << (k * WORD_W));
    return r;
  endfunction

  function automatic logic [OP_W-1:0] rnd_op();
    logic [OP_W-1:0] r;
    r = '0;
    for (int k = 0; k < NWORDS; k++) r = (r << WORD_W) | OP_W'($urandom());
    return r;
  endfunction

  task automatic rand_ops();
    for (int k = 0; k < NWORDS; k++) begin
      xw[k] = $urandom();
      yw[k] = $urandom();
      qw[k] = $urandom();
    end
  endtask

  task automatic load_ops(input bit bubbles, input bit early_done);
    int acc = 0;
    int cyc = 0;
    bit take;
    while (acc < 2 * NWORDS && cyc < 400) begin
      in_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (in_valid) in_data = (acc < NWORDS) ? xw[acc] : yw[acc - NWORDS];
      else          in_data = $urandom();
      mm_done = early_done && (acc >= NWORDS) && ($urandom_range(0, 1) == 1);
      mm_Q = rnd_op();
      check_val("no_early_start", {255'd0, mm_start}, 256'd0);
      take = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (take) acc++;
      cyc++;
    end
    in_valid = 1'b0;
    mm_done  = 1'b0;
    if (acc < 2 * NWORDS) check_val("load_timeout", OP_W'(acc), OP_W'(2 * NWORDS));
    check_val("start_pulse", {255'd0, mm_start}, 256'd1);
    check_val("in_ready_start", {255'd0, in_ready}, 256'd0);
    check_val("busy_start", {255'd0, busy}, 256'd1);
    check_val("mm_X", mm_X, pack(xw));
    check_val("mm_Y", mm_Y, pack(yw));
  endtask

  // mode 0: out_ready always 1; mode 1: pattern 1,0,0,...; mode 2: random
  task automatic compute_drain(input int lat, input int mode);
    int idx = 0;
    int cyc = 0;
    bit take;
    tick();
    check_val("start_one_cycle", {255'd0, mm_start}, 256'd0);
    check_val("in_ready_wait", {255'd0, in_ready}, 256'd0);
    for (int i = 0; i < lat; i++) begin
      check_val("no_valid_wait", {255'd0, out_valid}, 256'd0);
      tick();
    end
    check_val("ops_stable", mm_X, pack(xw));
    mm_Q    = pack(qw);
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    mm_Q    = rnd_op();
    while (idx < NWORDS && cyc < 200) begin
      check_val("out_valid", {255'd0, out_valid}, 256'd1);
      check_val("out_data", OP_W'(out_data), OP_W'(qw[idx]));
      check_val("out_last", {255'd0, out_last}, {255'd0, (idx == NWORDS - 1)});
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      take = out_valid && out_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (take) idx++;
    end
    out_ready = 1'b0;
    if (idx < NWORDS) check_val("drain_timeout", OP_W'(idx), OP_W'(NWORDS));
    if (mode == 0) check_val("drain_len", OP_W'(cyc), OP_W'(NWORDS));
    check_val("valid_after", {255'd0, out_valid}, 256'd0);
    check_val("last_after", {255'd0, out_last}, 256'd0);
    check_val("in_ready_after", {255'd0, in_ready}, 256'd1);
    check_val("busy_after", {255'd0, busy}, 256'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"}, {255'd0, in_ready}, 256'd0);
    check_val({tag, "_out_valid"}, {255'd0, out_valid}, 256'd0);
    check_val({tag, "_out_last"}, {255'd0, out_last}, 256'd0);
    check_val({tag, "_out_data"}, OP_W'(out_data), 256'd0);
    check_val({tag, "_mm_start"}, {255'd0, mm_start}, 256'd0);
    check_val({tag, "_mm_X"}, mm_X, 256'd0);
    check_val({tag, "_mm_Y"}, mm_Y, 256'd0);
    check_val({tag, "_busy"}, {255'd0, busy}, 256'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    mm_Q      = '0;
    mm_done   = 1'b0;

    // Reset held for 3 cycles, then release.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_outputs("reset");
    end
    rst = 1'b1;
    #1;
    check_val("idle_in_ready", {255'd0, in_ready}, 256'd0);
    tick();
    tick();
    check_val("load_in_ready", {255'd0, in_ready}, 256'd1);
    check_val("load_busy", {255'd0, busy}, 256'd0);

    // Directed operands, stub core latency 12, out_ready held high.
    for (int k = 0; k < NWORDS; k++) begin
      xw[k] = WORD_W'(k + 1);
      yw[k] = 32'h11111111 * WORD_W'(k + 1);
      qw[k] = 32'hA0000000 + WORD_W'(k);
    end
    load_ops(1'b0, 1'b0);
    compute_drain(11, 0);

    // Backpressure pattern 1,0,0,...
    rand_ops();
    load_ops(1'b0, 1'b0);
    compute_drain(5, 1);

    // Input bubbles, spurious mm_done during LOAD_Y, random backpressure.
    for (int r = 0; r < 3; r++) begin
      rand_ops();
      load_ops(1'b1, 1'b1);
      compute_drain($urandom_range(0, 15), 2);
    end

    // Reset while waiting on the core; late mm_done must be ignored.
    rand_ops();
    load_ops(1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    rst     = 1'b1;
    mm_done = 1'b1;
    mm_Q    = pack(qw);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("abort_no_valid", {255'd0, out_valid}, 256'd0);
    end
    mm_done = 1'b0;
    rand_ops();
    load_ops(1'b0, 1'b0);
    compute_drain(3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
